// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//
// Unsigned shift-and-add multiplier. One partial-product addition per clock
// goes through an internal ripple-carry adder (RCA). After SIZE additions the
// 2*SIZE-bit product is presented together with a one-cycle done pulse.
//
// Parameters:
//   SIZE     operand width (>= 1), passed unchanged to the internal RCA
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    request a multiplication (sampled only in IDLE)
//   a        multiplicand, captured on the accepting edge
//   b        multiplier, captured on the accepting edge
//   busy     high while in RUN
//   done     one-cycle completion pulse (high only in DONE)
//   product  result; holds until the next completion, cleared by reset
//
// Optional feature:
//   SEQ_MULTIPLIER_ZERO_SKIP_EN  when defined, a zero operand at the accepting
//                                edge goes IDLE->DONE directly with product=0.
// ----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PW = 2 * SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [SIZE-1:0] mcand;
    logic [SIZE-1:0] acc_hi;
    logic [SIZE-1:0] acc_lo;
    logic [CW-1:0]   cnt;

    logic [SIZE-1:0] rca_b;
    logic [SIZE:0]   sum;
    logic [PW:0]     acc_wide;
    logic [PW-1:0]   acc_next;

    logic            load;
    logic            step;
    logic            last;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
    logic            skip;
`endif

    // Partial-product adder: acc_hi + (multiplier LSB ? multiplicand : 0).
    assign rca_b = acc_lo[0] ? mcand : '0;

    RCA #(.SIZE(SIZE)) u_rca (
        .a   (acc_hi),
        .b   (rca_b),
        .sum (sum)
    );

    // {carry, sum, acc_lo} shifted right by one keeps the carry as the new
    // MSB of acc_hi and drops the multiplier bit just consumed. Written as a
    // shift so it stays legal for SIZE=1.
    assign acc_wide = {sum, acc_lo};
    assign acc_next = PW'(acc_wide >> 1);
    assign last     = (cnt == '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // values from before the edge, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
        skip       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        skip       = 1'b1;
                        state_next = DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = RUN;
                    end
`else
                    load       = 1'b1;
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (load) begin
                mcand  <= a;
                acc_lo <= b;
                acc_hi <= '0;
                cnt    <= CW'(SIZE - 1);
            end
            if (step) begin
                {acc_hi, acc_lo} <= acc_next;
                // Final addition: publish the updated accumulator on this edge.
                if (last) product <= acc_next;
                else      cnt     <= cnt - 1'b1;
            end
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
            if (skip) product <= '0;
`endif
        end
    end

endmodule

// ----------------------------------------------------------------------------
// RCA
//
// Combinational ripple-carry adder, SIZE bits wide, carry-in tied to zero.
//
// Ports:
//   a, b   SIZE-bit addends
//   sum    SIZE+1-bit result; sum[SIZE] is the carry out
// ----------------------------------------------------------------------------
module RCA #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   sum
);

    logic [SIZE:0] carry;

    always_comb begin
        carry[0] = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        sum[SIZE] = carry[SIZE];
    end

endmodule
